// File: rtl/rr_stream_mux.sv
// rr_stream_mux: packet-locked stream mux driven by an external
// round-robin arbiter, with a registered single-beat output stage.
module rr_stream_mux #(
  parameter int PORTS  = 2,
  parameter int DATA_W = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [PORTS-1:0]          i_valid,
  input  logic [PORTS*DATA_W-1:0]   i_data,
  input  logic [PORTS-1:0]          i_last,
  output logic [PORTS-1:0]          o_ready,
  output logic [PORTS-1:0]          o_req_vec,
  input  logic [PORTS-1:0]          i_grant_vec,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_last,
  output logic [$clog2(PORTS)-1:0]  o_src,
  input  logic                      i_ready,
  output logic                      o_grant_err
);

  localparam int SRC_W = $clog2(PORTS);

  typedef enum logic {
    IDLE,
    PKT
  } lock_e;

  lock_e             state_q, state_d;
  logic [SRC_W-1:0]  lock_q, lock_d;
  logic [PORTS-1:0]  rel_q, rel_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              err_q, err_d;

  logic              grant_multi;
  logic              grant_one;
  logic              load_en;
  logic [PORTS-1:0]  lock_mask;
  logic [PORTS-1:0]  acc_vec;
  logic              accept;
  logic [SRC_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;

  // Handshake, request masking and accepted-beat selection.
  always_comb begin
    grant_multi = |(i_grant_vec & (i_grant_vec - PORTS'(1)));
    grant_one   = (i_grant_vec != '0) && !grant_multi;
    load_en     = !valid_q || i_ready;
    lock_mask   = '0;
    lock_mask[lock_q] = 1'b1;
    o_ready     = '0;
    if (i_rstn && grant_one && load_en)
      o_ready = i_grant_vec;
    o_req_vec = '0;
    if (i_rstn) begin
      if (state_q == PKT)
        o_req_vec = i_valid & lock_mask;
      else
        o_req_vec = i_valid & ~rel_q;
    end
    acc_vec  = i_valid & o_ready;
    accept   = |acc_vec;
    acc_idx  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (acc_vec[p]) begin
        acc_idx  = SRC_W'(p);
        acc_data = i_data[p*DATA_W +: DATA_W];
        acc_last = i_last[p];
      end
    end
  end

  // Lock FSM, release mask, output register and sticky grant error.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rel_d   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    src_d   = src_q;
    err_d   = err_q | grant_multi
            | (|(i_grant_vec & ~o_req_vec));
    unique case (state_q)
      IDLE: if (accept && !acc_last) begin
        state_d = PKT;
        lock_d  = acc_idx;
      end
      PKT: if (accept && acc_last)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && acc_last)
      rel_d[acc_idx] = 1'b1;
    if (load_en) begin
      valid_d = accept;
      if (accept) begin
        data_d = acc_data;
        last_d = acc_last;
        src_d  = acc_idx;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_last      = last_q;
  assign o_src       = src_q;
  assign o_grant_err = err_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: random + directed streams against per-port
// expected queues, with a behavioural round-robin arbiter.
module tb_rr_stream_mux;
  localparam int P = 2;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic [P-1:0] valid, last, ready, req, grant;
  logic [P*W-1:0] data;
  logic         ov, ol, ir, gerr;
  logic [W-1:0] od;
  logic [0:0]   osrc;

  always #5 clk = ~clk;

  rr_stream_mux #(.PORTS(P), .DATA_W(W)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_valid(valid), .i_data(data), .i_last(last),
    .o_ready(ready), .o_req_vec(req), .i_grant_vec(grant),
    .o_valid(ov), .o_data(od), .o_last(ol), .o_src(osrc),
    .i_ready(ir), .o_grant_err(gerr)
  );

  beat_t src_q[P][$];
  beat_t exp_q[P][$];
  logic [P-1:0] en;
  logic         force_v;
  logic         use_fg;
  logic [P-1:0] force_g;
  int ptr, nptr;
  int n_chk, n_fail;
  int acc_cnt;
  int acc_p[P];

  bit           lk_v;
  int           lk;
  logic [P-1:0] rel, nrel, exp_req, exp_rdy;
  bit           err_m;
  int           out_lock;
  bit           hold_v;
  logic [W-1:0] hold_d;
  logic         hold_l;
  logic [0:0]   hold_s;
  beat_t        b, e;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  // Round-robin arbiter: first requester after the last served port.
  always_comb begin
    grant = '0;
    if (use_fg)
      grant = force_g;
    else
      for (int k = 1; k <= P; k++)
        if (req[(ptr + k) % P] && grant == '0)
          grant[(ptr + k) % P] = 1'b1;
  end

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      valid[p] = force_v || (en[p] && src_q[p].size() > 0);
      if (src_q[p].size() > 0) begin
        data[p*W +: W] = src_q[p][0].d;
        last[p]        = src_q[p][0].l;
      end else begin
        data[p*W +: W] = '0;
        last[p]        = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ptr = nptr;
    drive();
  endtask

  task automatic gen_pkt(input int p, input int len);
    beat_t nb;
    for (int i = 0; i < len; i++) begin
      nb.d = $urandom;
      nb.l = (i == len - 1);
      src_q[p].push_back(nb);
      exp_q[p].push_back(nb);
    end
  endtask

  function automatic bit busy();
    for (int p = 0; p < P; p++)
      if (src_q[p].size() > 0 || exp_q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int c = 0;
    while (busy() && c < budget) begin
      tick();
      c++;
    end
    n_chk++;
    if (busy()) begin
      n_fail++;
      $display("FAIL drain: queues still busy after %0d cycles", c);
    end
  endtask

  task automatic wait_acc(input int p, input int target);
    int c = 0;
    while (acc_p[p] < target && c < 100) begin
      tick();
      c++;
    end
    n_chk++;
    if (acc_p[p] < target) begin
      n_fail++;
      $display("FAIL wait_acc: port %0d got %0d beats need %0d",
               p, acc_p[p], target);
    end
  endtask

  // Monitor/scoreboard: rule checks and output beat comparison.
  always @(negedge clk) begin
    if (!rstn) begin
      lk_v = 0;
      rel = '0;
      out_lock = -1;
      hold_v = 0;
      err_m = 0;
    end else begin
      exp_req = lk_v ? (valid & (P'(1) << lk)) : (valid & ~rel);
      chk("req_vec", 64'(req), 64'(exp_req));
      exp_rdy = ($onehot(grant) && (!ov || ir)) ? grant : '0;
      chk("o_ready", 64'(ready), 64'(exp_rdy));
      chk("grant_err", 64'(gerr), 64'(err_m));
      if (hold_v) begin
        chk("hold_valid", 64'(ov), 64'(1));
        chk("hold_data", 64'(od), 64'(hold_d));
        chk("hold_last", 64'(ol), 64'(hold_l));
        chk("hold_src", 64'(osrc), 64'(hold_s));
      end
      if (ov && ir) begin
        if (exp_q[osrc].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_beat: src %0d data %0h none expected",
                   osrc, od);
        end else begin
          e = exp_q[osrc].pop_front();
          chk("out_data", 64'(od), 64'(e.d));
          chk("out_last", 64'(ol), 64'(e.l));
        end
        if (out_lock >= 0)
          chk("interleave", 64'(osrc), 64'(out_lock));
        out_lock = ol ? -1 : int'(osrc);
      end
      hold_v = ov && !ir;
      hold_d = od;
      hold_l = ol;
      hold_s = osrc;
      if (!$onehot0(grant) || (grant & ~req) != '0) err_m = 1;
      nrel = '0;
      for (int p = 0; p < P; p++) begin
        if (valid[p] && ready[p]) begin
          b = src_q[p].pop_front();
          acc_cnt++;
          acc_p[p]++;
          nptr = p;
          if (b.l) begin
            nrel[p] = 1'b1;
            lk_v = 0;
          end else begin
            lk_v = 1;
            lk = p;
          end
        end
      end
      rel = nrel;
    end
  end

  initial begin
    int base;
    n_chk = 0; n_fail = 0; acc_cnt = 0;
    for (int p = 0; p < P; p++) acc_p[p] = 0;
    ptr = P - 1; nptr = P - 1;
    en = '0; force_v = 1'b1; use_fg = 1'b0; force_g = '0;
    ir = 1'b1; rstn = 1'b0;
    drive();
    repeat (3) tick();
    @(negedge clk); #1;
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_valid", 64'(ov), 64'(0));
    chk("rst_err", 64'(gerr), 64'(0));
    tick();
    rstn = 1'b1; force_v = 1'b0;
    drive();
    tick();

    // Two 3-beat packets competing.
    gen_pkt(0, 3);
    gen_pkt(1, 3);
    en = 2'b11;
    drive();
    drain(100);

    // Locked port drops valid mid-packet.
    gen_pkt(0, 4);
    gen_pkt(1, 2);
    base = acc_p[0];
    drive();
    wait_acc(0, base + 2);
    en = 2'b10;
    drive();
    base = acc_p[1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("drop_req", 64'(req), 64'(0));
      chk("drop_p1_held", 64'(acc_p[1]), 64'(base));
      tick();
    end
    en = 2'b11;
    drive();
    drain(100);

    // Backpressure mid-packet.
    gen_pkt(0, 6);
    en = 2'b01;
    base = acc_p[0];
    drive();
    wait_acc(0, base + 2);
    ir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk); #1;
      chk("bp_ready", 64'(ready), 64'(0));
      chk("bp_valid", 64'(ov), 64'(1));
    end
    tick();
    ir = 1'b1;
    drain(100);

    // Single requester with 1-beat packets: release bubble.
    repeat (3) tick();
    for (int i = 0; i < 15; i++) gen_pkt(1, 1);
    en = 2'b10;
    drive();
    base = acc_cnt;
    repeat (20) tick();
    chk("bubble_rate", 64'(acc_cnt - base), 64'(10));
    drain(100);

    // Random traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < P; p++) begin
        if (src_q[p].size() < 4) gen_pkt(p, $urandom_range(1, 5));
        en[p] = ($urandom % 4) != 0;
      end
      ir = ($urandom % 4) != 0;
      tick();
    end
    en = 2'b11;
    ir = 1'b1;
    drive();
    drain(500);
    chk("no_grant_err", 64'(gerr), 64'(0));

    // Illegal grant: sticky error, nothing accepted.
    en = '0;
    drive();
    tick();
    base = acc_cnt;
    use_fg = 1'b1;
    force_g = 2'b11;
    tick();
    use_fg = 1'b0;
    repeat (4) tick();
    @(negedge clk); #1;
    chk("err_sticky", 64'(gerr), 64'(1));
    chk("err_no_accept", 64'(acc_cnt), 64'(base));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
